// File: rtl/sha256_pad_ctrl_pkg.sv
// rtl/sha256_pad_ctrl_pkg.sv - shared constants and state types for the sha256 padding controller
package sha256_pad_ctrl_pkg;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFS     = 56;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_PAD,
    ST_PAD2,
    ST_DONE
  } state_e;

  // What the FSM does once the core returns the block currently in flight
  typedef enum logic [1:0] {
    NX_FILL,
    NX_PAD,
    NX_PAD2,
    NX_DONE
  } after_e;

endpackage

// File: rtl/sha256_pad_ctrl_if.sv
// rtl/sha256_pad_ctrl_if.sv - byte stream, core and digest handshakes of the padding controller
interface sha256_pad_ctrl_if;

  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [255:0] core_H;
  logic [511:0] core_M;
  logic         core_start;
  logic [255:0] core_H_res;
  logic         core_done;
  logic [255:0] dig_data;
  logic         dig_valid;
  logic         dig_ready;

  // Environment side: message source, hash core and digest sink
  modport master (
    output in_data, in_valid, in_last, core_H_res, core_done, dig_ready,
    input  in_ready, core_H, core_M, core_start, dig_data, dig_valid
  );

  // Controller side
  modport slave (
    input  in_data, in_valid, in_last, core_H_res, core_done, dig_ready,
    output in_ready, core_H, core_M, core_start, dig_data, dig_valid
  );

endinterface

// File: rtl/sha256_pad_ctrl_buf.sv
// rtl/sha256_pad_ctrl_buf.sv - 64-byte block register with byte write and padding tail insert
module sha256_pad_ctrl_buf
  import sha256_pad_ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [5:0]   i_ptr,
  input  logic [7:0]   i_data,
  input  logic         i_fill,
  input  logic [6:0]   i_fill_from,
  input  logic         i_mark,
  input  logic         i_len_en,
  input  logic [63:0]  i_len,
  output logic [511:0] o_block
);

  logic [511:0] r_block;

  // Byte 0 sits in the top byte; the tail from i_fill_from up gets 0x80, zeros and optionally the length
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_block <= '0;
    end else begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (i_wr && (i_ptr == 6'(i))) begin
          r_block[511-8*i -: 8] <= i_data;
        end
        if (i_fill && (7'(i) >= i_fill_from)) begin
          if (i_mark && (7'(i) == i_fill_from)) begin
            r_block[511-8*i -: 8] <= 8'h80;
          end else if (i_len_en && (i >= LEN_OFS)) begin
            r_block[511-8*i -: 8] <= i_len[8*(BLOCK_BYTES-1-i) +: 8];
          end else begin
            r_block[511-8*i -: 8] <= 8'h00;
          end
        end
      end
    end
  end

  assign o_block = r_block;

endmodule

// File: rtl/sha256_pad_ctrl.sv
// rtl/sha256_pad_ctrl.sv - sha256 message padder and block sequencer feeding the round core
module sha256_pad_ctrl
  import sha256_pad_ctrl_pkg::*;
#(
  parameter int LEN_W    = 64,
  parameter int CORE_LAT = 66
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  sha256_pad_ctrl_if.slave bus,
  output logic             o_err
);

  localparam int WD_W = $clog2(CORE_LAT + 1);

  state_e           r_state, w_state_nxt;
  after_e           r_after, w_after_nxt;
  logic [5:0]       r_ptr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic [255:0]     r_core_H;
  logic             r_core_start;
  logic             r_err;
  logic [WD_W-1:0]  r_wdog;

  logic             w_in_ready;
  logic             w_wr;
  logic             w_fill;
  logic             w_mark;
  logic             w_len_en;
  logic [6:0]       w_fill_from;
  logic [63:0]      w_len_field;
  logic [511:0]     w_block;
  logic             w_start_nxt;

  assign w_len_nxt   = r_len + LEN_W'(8);
  // In FILL the length field must already count the byte being written this cycle
  assign w_len_field = (r_state == ST_FILL) ? 64'(w_len_nxt) : 64'(r_len);
  assign w_start_nxt = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);

  // Next-state and block-buffer control
  always_comb begin
    w_state_nxt = r_state;
    w_after_nxt = r_after;
    w_in_ready  = 1'b0;
    w_wr        = 1'b0;
    w_fill      = 1'b0;
    w_fill_from = 7'd0;
    w_mark      = 1'b0;
    w_len_en    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_FILL;
      ST_FILL: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_wr = 1'b1;
          if (bus.in_last) begin
            w_state_nxt = ST_RUN;
            w_fill_from = 7'(r_ptr) + 7'd1;
            if (r_ptr <= 6'(LEN_OFS - 2)) begin
              w_fill      = 1'b1;
              w_mark      = 1'b1;
              w_len_en    = 1'b1;
              w_after_nxt = NX_DONE;
            end else if (r_ptr != 6'(BLOCK_BYTES - 1)) begin
              w_fill      = 1'b1;
              w_mark      = 1'b1;
              w_after_nxt = NX_PAD2;
            end else begin
              w_after_nxt = NX_PAD;
            end
          end else if (r_ptr == 6'(BLOCK_BYTES - 1)) begin
            w_state_nxt = ST_RUN;
            w_after_nxt = NX_FILL;
          end
        end
      end
      ST_RUN: begin
        if (bus.core_done) begin
          case (r_after)
            NX_FILL: w_state_nxt = ST_FILL;
            NX_PAD:  w_state_nxt = ST_PAD;
            NX_PAD2: w_state_nxt = ST_PAD2;
            default: w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_PAD: begin
        w_fill      = 1'b1;
        w_mark      = 1'b1;
        w_len_en    = 1'b1;
        w_after_nxt = NX_DONE;
        w_state_nxt = ST_RUN;
      end
      ST_PAD2: begin
        w_fill      = 1'b1;
        w_len_en    = 1'b1;
        w_after_nxt = NX_DONE;
        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (bus.dig_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, byte pointer, length, chaining state and core watchdog
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_after      <= NX_FILL;
      r_ptr        <= '0;
      r_len        <= '0;
      r_core_H     <= H0;
      r_core_start <= 1'b0;
      r_err        <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_after      <= w_after_nxt;
      r_core_start <= w_start_nxt;
      if (w_wr) begin
        r_ptr <= r_ptr + 6'd1;
        r_len <= w_len_nxt;
      end
      if ((r_state == ST_RUN) && bus.core_done) begin
        r_core_H <= bus.core_H_res;
        r_ptr    <= '0;
      end
      if ((r_state == ST_DONE) && bus.dig_ready) begin
        r_core_H <= H0;
        r_len    <= '0;
      end
      // r_wdog equals the number of cycles since core_start; it saturates at the bound
      if (r_core_start) begin
        r_wdog <= WD_W'(1);
      end else if ((r_state == ST_RUN) && (r_wdog != WD_W'(CORE_LAT))) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      if ((r_state == ST_RUN) && !r_core_start && !bus.core_done && (r_wdog == WD_W'(CORE_LAT))) begin
        r_err <= 1'b1;
      end
    end
  end

  sha256_pad_ctrl_buf u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr        (w_wr),
    .i_ptr       (r_ptr),
    .i_data      (bus.in_data),
    .i_fill      (w_fill),
    .i_fill_from (w_fill_from),
    .i_mark      (w_mark),
    .i_len_en    (w_len_en),
    .i_len       (w_len_field),
    .o_block     (w_block)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.core_H     = r_core_H;
  assign bus.core_M     = w_block;
  assign bus.core_start = r_core_start;
  assign bus.dig_valid  = (r_state == ST_DONE);
  assign bus.dig_data   = (r_state == ST_DONE) ? r_core_H : '0;
  assign o_err          = r_err;

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// tb/tb_sha256_pad_ctrl.sv - self-checking bench for the sha256 padding controller
module tb_sha256_pad_ctrl;

  localparam int CORE_LAT = 66;
  localparam logic [255:0] H_INIT = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  int n_checks = 0;
  int n_errors = 0;
  int blk_total = 0;
  int blk_mark = 0;
  int dig_seen = 0;
  logic stall = 1'b0;
  logic [511:0] last_core_M;
  logic [255:0] last_dig;

  logic [511:0] exp_m_q[$];
  logic [255:0] exp_h_q[$];
  logic [255:0] exp_dig_q[$];
  int exp_nb_q[$];

  sha256_pad_ctrl_if bus ();

  sha256_pad_ctrl #(.LEN_W(64), .CORE_LAT(CORE_LAT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic clear_expect();
    exp_m_q.delete();
    exp_h_q.delete();
    exp_dig_q.delete();
    exp_nb_q.delete();
    blk_mark = blk_total;
  endtask

  // Behavioural core: checks each issued block against the scoreboard, answers after CORE_LAT cycles
  task automatic core_model();
    logic busy = 1'b0;
    int cnt = 0;
    logic [255:0] res = '0;
    logic [511:0] m_cap = '0;
    logic [511:0] em;
    logic [255:0] eh;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
        continue;
      end
      if (busy) begin
        cnt++;
        if (!stall && cnt == CORE_LAT) begin
          n_checks++;
          if (bus.core_M !== m_cap) begin
            n_errors++;
            $display("FAIL core_M_stable: got %h required %h", bus.core_M, m_cap);
          end
          bus.core_done = 1'b1;
          bus.core_H_res = res;
          busy = 1'b0;
        end
      end
      if (bus.core_start) begin
        blk_total++;
        last_core_M = bus.core_M;
        n_checks++;
        if (exp_m_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_core_start: got block %h required none", bus.core_M);
        end else begin
          em = exp_m_q.pop_front();
          eh = exp_h_q.pop_front();
          if (bus.core_M !== em) begin
            n_errors++;
            $display("FAIL core_M: got %h required %h", bus.core_M, em);
          end
          n_checks++;
          if (bus.core_H !== eh) begin
            n_errors++;
            $display("FAIL core_H: got %h required %h", bus.core_H, eh);
          end
        end
        res = compress(bus.core_H, bus.core_M);
        m_cap = bus.core_M;
        busy = 1'b1;
        cnt = 0;
      end
    end
  endtask

  // Digest sink: compares each accepted digest and the number of blocks it took
  task automatic dig_monitor();
    logic [255:0] ed;
    int enb;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dig_valid && bus.dig_ready) begin
        last_dig = bus.dig_data;
        dig_seen++;
        n_checks++;
        if (exp_dig_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_digest: got %h required none", bus.dig_data);
        end else begin
          ed = exp_dig_q.pop_front();
          enb = exp_nb_q.pop_front();
          if (bus.dig_data !== ed) begin
            n_errors++;
            $display("FAIL digest: got %h required %h", bus.dig_data, ed);
          end
          n_checks++;
          if ((blk_total - blk_mark) !== enb) begin
            n_errors++;
            $display("FAIL block_count: got %0d required %0d", blk_total - blk_mark, enb);
          end
        end
        blk_mark = blk_total;
      end
    end
  endtask

  // Pads the message independently, pushes expected blocks/chain/digest, then streams the bytes
  task automatic drive_msg(input bq_t msg);
    bq_t p;
    logic [63:0] len;
    logic [511:0] blk;
    logic [255:0] h;
    logic acc;
    int tmo;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int k = 0; k < 8; k++) p.push_back(len[63-8*k -: 8]);
    h = H_INIT;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_m_q.push_back(blk);
      exp_h_q.push_back(h);
      h = compress(h, blk);
    end
    exp_dig_q.push_back(h);
    exp_nb_q.push_back(p.size() / 64);
    for (int i = 0; i < msg.size(); i++) begin
      bus.in_data = msg[i];
      bus.in_valid = 1'b1;
      bus.in_last = (i == msg.size() - 1);
      tmo = 0;
      acc = 1'b0;
      while (!acc && tmo < 2000) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        tmo++;
      end
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL in_ready_timeout: got no accept for byte %0d required accept", i);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_dig(input int target);
    int tmo = 0;
    while (dig_seen < target && tmo < 5000) begin
      @(posedge clk);
      tmo++;
    end
    if (dig_seen < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL digest_timeout: got %0d digests required %0d", dig_seen, target);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input int n, output bq_t m);
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'h61);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.core_done = 1'b0;
    bus.core_H_res = '0;
    bus.dig_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    n_checks++; if (bus.core_start !== 1'b0) begin n_errors++; $display("FAIL rst_core_start: got %b required 0", bus.core_start); end
    n_checks++; if (bus.dig_valid !== 1'b0) begin n_errors++; $display("FAIL rst_dig_valid: got %b required 0", bus.dig_valid); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b required 0", err); end
    n_checks++; if (bus.core_M !== 512'h0) begin n_errors++; $display("FAIL rst_core_M: got %h required 0", bus.core_M); end
    n_checks++; if (bus.core_H !== H_INIT) begin n_errors++; $display("FAIL rst_core_H: got %h required %h", bus.core_H, H_INIT); end
    n_checks++; if (bus.dig_data !== 256'h0) begin n_errors++; $display("FAIL rst_dig_data: got %h required 0", bus.dig_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL idle_in_ready: got %b required 0", bus.in_ready); end
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL fill_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    bq_t m;
    int base = dig_seen;
    m = {8'h61, 8'h62, 8'h63};
    drive_msg(m);
    wait_dig(base + 1);
    n_checks++;
    if (last_core_M !== {32'h61626380, 416'h0, 64'h18}) begin
      n_errors++; $display("FAIL abc_block: got %h required 6162638000..0018", last_core_M);
    end
    n_checks++;
    if (last_dig !== ABC_DIG) begin n_errors++; $display("FAIL abc_digest: got %h required %h", last_dig, ABC_DIG); end
  endtask

  task automatic test_boundaries();
    int lens [4] = '{55, 56, 63, 64};
    bq_t m;
    logic [511:0] req;
    for (int k = 0; k < 4; k++) begin
      fill_a(lens[k], m);
      drive_msg(m);
      wait_dig(dig_seen + 1);
      case (lens[k])
        55:      req = {{55{8'h61}}, 8'h80, 64'h1b8};
        56:      req = {448'h0, 64'h1c0};
        63:      req = {448'h0, 64'h1f8};
        default: req = {8'h80, 440'h0, 64'h200};
      endcase
      n_checks++;
      if (last_core_M !== req) begin
        n_errors++; $display("FAIL boundary_%0d_last_block: got %h required %h", lens[k], last_core_M, req);
      end
    end
  endtask

  task automatic test_pubkey();
    logic [263:0] pk = {8'h02, 128'h79be667ef9dcbbac55a06295ce870b07, 128'h029bfcdb2dce28d959f2815b16f81798};
    bq_t m;
    m = {};
    for (int i = 0; i < 33; i++) m.push_back(pk[263-8*i -: 8]);
    drive_msg(m);
    wait_dig(dig_seen + 1);
  endtask

  task automatic test_back_to_back();
    bq_t m1, m2;
    int base = dig_seen;
    m1 = {};
    for (int i = 0; i < 130; i++) m1.push_back(8'($urandom_range(0, 255)));
    m2 = {8'h00};
    drive_msg(m1);
    drive_msg(m2);
    wait_dig(base + 2);
  endtask

  task automatic test_dig_hold();
    bq_t m;
    logic [255:0] cap;
    logic stable = 1'b1;
    logic ready_low = 1'b1;
    int tmo = 0;
    int base = dig_seen;
    bus.dig_ready = 1'b0;
    fill_a(10, m);
    drive_msg(m);
    while (!bus.dig_valid && tmo < 1000) begin
      @(negedge clk);
      tmo++;
    end
    n_checks++;
    if (bus.dig_valid !== 1'b1) begin n_errors++; $display("FAIL hold_dig_valid_timeout: got %b required 1", bus.dig_valid); end
    cap = bus.dig_data;
    bus.in_data = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.dig_valid !== 1'b1 || bus.dig_data !== cap) stable = 1'b0;
      if (bus.in_ready !== 1'b0) ready_low = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin n_errors++; $display("FAIL hold_dig_stable: got %b required 1", stable); end
    n_checks++;
    if (ready_low !== 1'b1) begin n_errors++; $display("FAIL hold_in_ready_low: got %b required 1", ready_low); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dig_ready = 1'b1;
    wait_dig(base + 1);
  endtask

  task automatic test_reset_mid_run();
    bq_t m;
    int tmo = 0;
    int target = blk_total + 2;
    int base;
    fill_a(100, m);
    drive_msg(m);
    while (blk_total < target && tmo < 1000) begin
      @(posedge clk);
      tmo++;
    end
    n_checks++;
    if (blk_total < target) begin n_errors++; $display("FAIL midrun_block2_timeout: got %0d blocks required %0d", blk_total, target); end
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_expect();
    rst_n = 1'b1;
    base = dig_seen;
    m = {8'h61, 8'h62, 8'h63};
    drive_msg(m);
    wait_dig(base + 1);
    n_checks++;
    if (last_dig !== ABC_DIG) begin n_errors++; $display("FAIL midrun_abc_digest: got %h required %h", last_dig, ABC_DIG); end
  endtask

  task automatic test_watchdog();
    bq_t m;
    stall = 1'b1;
    m = {8'h61, 8'h62, 8'h63};
    drive_msg(m);
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL wdog_early_err: got %b required 0", err); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_errors++; $display("FAIL wdog_err: got %b required 1", err); end
    n_checks++;
    if (bus.dig_valid !== 1'b0) begin n_errors++; $display("FAIL wdog_still_waiting: got dig_valid %b required 0", bus.dig_valid); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL wdog_err_cleared: got %b required 0", err); end
    clear_expect();
    stall = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    fork
      core_model();
      dig_monitor();
      begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "global timeout");
      end
    join_none
    test_reset();
    test_abc();
    test_boundaries();
    test_pubkey();
    test_back_to_back();
    test_dig_hold();
    test_reset_mid_run();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
